// File: rtl/ssr_byte_source.sv
// -----------------------------------------------------------------------------
// ssr_byte_source
//
// Upstream byte producer for the gpio byte receiver. A full frame of FRAME_LEN
// bytes is captured from a byte-wide write port into a local buffer. The frame
// is then served one byte at a time over a 4-phase handshake:
//
//   receiver raises readssr_req
//   -> this block loads byte_out, then raises byte_ready one clock later
//   -> receiver latches byte_out and raises byte_received_ack
//   -> byte_ready falls, receiver drops ack, next byte follows.
//
// The receiver runs on a divided clock, so readssr_req and byte_received_ack
// are treated as asynchronous levels and pass through SYNC_STAGES flops.
// byte_ready and byte_out come straight from flops, so they never glitch.
//
// Ports
//   clk                in   1       system clock (the receiver divides this down)
//   rst                in   1       asynchronous, active-high reset
//   wr_en              in   1       write strobe, one byte per cycle
//   wr_data            in   DATA_W  byte appended to the frame buffer
//   readssr_req        in   1       receiver wants bytes (level, async to clk)
//   byte_received_ack  in   1       receiver has latched byte_out (level, async)
//   byte_ready         out  1       byte_out valid, held until the ack is seen
//   byte_out           out  DATA_W  current byte; holds its value after frame end
//   frame_loaded       out  1       full frame buffered and not yet fully sent
//   frame_sent         out  1       one-cycle pulse once the last byte completes
//   busy               out  1       block is anywhere but the LOAD state
//   overrun            out  1       sticky: a write arrived outside LOAD
// -----------------------------------------------------------------------------
module ssr_byte_source #(
    parameter int FRAME_LEN   = 40,
    parameter int DATA_W      = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              readssr_req,
    input  logic              byte_received_ack,
    output logic              byte_ready,
    output logic [DATA_W-1:0] byte_out,
    output logic              frame_loaded,
    output logic              frame_sent,
    output logic              busy,
    output logic              overrun
);

    localparam int IDX_W = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);
    localparam logic [IDX_W-1:0] IDX_ONE  = {{(IDX_W-1){1'b0}}, 1'b1};
    localparam logic [IDX_W-1:0] IDX_ZERO = {IDX_W{1'b0}};

    // Explicit encodings so that the three spare codes are recognisably
    // illegal and fall into the recovery branch of the state machine.
    typedef enum logic [2:0] {
        ST_LOAD         = 3'd0,
        ST_WAIT_REQ     = 3'd1,
        ST_PRESENT      = 3'd2,
        ST_WAIT_ACK     = 3'd3,
        ST_WAIT_ACK_LOW = 3'd4
    } state_t;

    // Advance a frame index. Anything at or beyond the last slot wraps to 0,
    // which keeps a corrupted index from walking outside the buffer.
    function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] idx);
        logic [IDX_W-1:0] nxt;
        if (idx >= LAST_IDX) begin
            nxt = IDX_ZERO;
        end else begin
            nxt = idx + IDX_ONE;
        end
        return nxt;
    endfunction

    // True when the index addresses the final byte of the frame (or beyond).
    function automatic logic is_last(input logic [IDX_W-1:0] idx);
        return (idx >= LAST_IDX);
    endfunction

    state_t                 state_r;
    logic [IDX_W-1:0]       wptr_r;
    logic [IDX_W-1:0]       rd_idx_r;
    logic [IDX_W-1:0]       rd_next_s;
    logic [SYNC_STAGES-1:0] req_sync_r;
    logic [SYNC_STAGES-1:0] ack_sync_r;
    logic                   req_s;
    logic                   ack_s;
    logic                   buf_we_s;
    logic                   byte_ready_r;
    logic [DATA_W-1:0]      byte_out_r;
    logic                   frame_loaded_r;
    logic                   frame_sent_r;
    logic                   busy_r;
    logic                   overrun_r;
    logic [DATA_W-1:0]      frame_buf_r [FRAME_LEN];

    // The synchronised level is taken from the last flop of each chain.
    assign req_s     = req_sync_r[SYNC_STAGES-1];
    assign ack_s     = ack_sync_r[SYNC_STAGES-1];
    assign rd_next_s = next_idx(rd_idx_r);

    // Writes only land in the buffer while a frame is being captured.
    assign buf_we_s  = wr_en && (state_r == ST_LOAD);

    assign byte_ready   = byte_ready_r;
    assign byte_out     = byte_out_r;
    assign frame_loaded = frame_loaded_r;
    assign frame_sent   = frame_sent_r;
    assign busy         = busy_r;
    assign overrun      = overrun_r;

    // Resynchronise the receiver's request and acknowledge levels into clk.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            req_sync_r <= {SYNC_STAGES{1'b0}};
            ack_sync_r <= {SYNC_STAGES{1'b0}};
        end else begin
            req_sync_r <= {req_sync_r[SYNC_STAGES-2:0], readssr_req};
            ack_sync_r <= {ack_sync_r[SYNC_STAGES-2:0], byte_received_ack};
        end
    end

    // Frame storage; contents are deliberately left alone by reset.
    always_ff @(posedge clk) begin
        if (buf_we_s) begin
            frame_buf_r[wptr_r] <= wr_data;
        end
    end

    // Sticky overrun flag: set by any write that arrives outside LOAD
    // (including the edge that returns to LOAD), cleared only by reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overrun_r <= 1'b0;
        end else if (wr_en && (state_r != ST_LOAD)) begin
            overrun_r <= 1'b1;
        end
    end

    // Main sequencer: frame capture, byte presentation and handshake tracking.
    // byte_out is loaded on the edge that enters PRESENT and byte_ready on the
    // edge that leaves it, so the data is stable one clock before it is
    // flagged valid.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r        <= ST_LOAD;
            wptr_r         <= IDX_ZERO;
            rd_idx_r       <= IDX_ZERO;
            byte_ready_r   <= 1'b0;
            byte_out_r     <= {DATA_W{1'b0}};
            frame_loaded_r <= 1'b0;
            frame_sent_r   <= 1'b0;
            busy_r         <= 1'b0;
        end else begin
            // frame_sent is a pulse; it is re-armed only on the final handshake.
            frame_sent_r <= 1'b0;
            case (state_r)
                ST_LOAD: begin
                    if (wr_en) begin
                        if (is_last(wptr_r)) begin
                            // Final byte of the frame is accepted on this edge.
                            wptr_r         <= IDX_ZERO;
                            frame_loaded_r <= 1'b1;
                            busy_r         <= 1'b1;
                            state_r        <= ST_WAIT_REQ;
                        end else begin
                            wptr_r <= wptr_r + IDX_ONE;
                        end
                    end
                end

                ST_WAIT_REQ: begin
                    // Frame and read index are held here for as long as needed.
                    if (req_s) begin
                        byte_out_r <= frame_buf_r[rd_idx_r];
                        state_r    <= ST_PRESENT;
                    end
                end

                ST_PRESENT: begin
                    byte_ready_r <= 1'b1;
                    state_r      <= ST_WAIT_ACK;
                end

                ST_WAIT_ACK: begin
                    // byte_ready is never withdrawn early, even if the request
                    // drops; the byte in flight always completes its handshake.
                    if (ack_s) begin
                        byte_ready_r <= 1'b0;
                        state_r      <= ST_WAIT_ACK_LOW;
                    end
                end

                ST_WAIT_ACK_LOW: begin
                    // The next byte waits until the ack has been seen low, so a
                    // long ack pulse cannot release more than one byte.
                    if (!ack_s) begin
                        if (is_last(rd_idx_r)) begin
                            rd_idx_r       <= IDX_ZERO;
                            frame_loaded_r <= 1'b0;
                            frame_sent_r   <= 1'b1;
                            busy_r         <= 1'b0;
                            state_r        <= ST_LOAD;
                        end else begin
                            rd_idx_r <= rd_next_s;
                            if (req_s) begin
                                byte_out_r <= frame_buf_r[rd_next_s];
                                state_r    <= ST_PRESENT;
                            end else begin
                                // Request withdrawn: park on the next byte.
                                state_r <= ST_WAIT_REQ;
                            end
                        end
                    end
                end

                default: begin
                    // Illegal encoding: drop any frame in progress and restart
                    // capture from a clean state.
                    state_r        <= ST_LOAD;
                    wptr_r         <= IDX_ZERO;
                    rd_idx_r       <= IDX_ZERO;
                    byte_ready_r   <= 1'b0;
                    frame_loaded_r <= 1'b0;
                    busy_r         <= 1'b0;
                end
            endcase
        end
    end

endmodule
